// File: rtl/cpu_bp_pkg.sv
// Shared branch-prediction constants: PF state encoding, reset/exception vectors
// and the BHT/BTB index and tag widths used by the predictor blocks.
package cpu_bp_pkg;

    localparam logic [0:0] PF_RUN  = 1'b0;
    localparam logic [0:0] PF_SLOT = 1'b1;

    localparam logic [31:0] CPU_RESET_PC  = 32'hBFC0_0000;
    localparam logic [31:0] CPU_EXC_ENTRY = 32'hBFC0_0380;

    localparam int BHT_IDX_W = 8;
    localparam int BTB_IDX_W = 7;
    localparam int BTB_TAG_W = 23;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } pf_pred_t;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pf_redirect_mux.sv
// Priority select of the next fetch PC: exception, then ERET, then EX redirect,
// otherwise the sequential/predicted PC chosen by the PF state machine.
module pf_redirect_mux
    import cpu_bp_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY = CPU_EXC_ENTRY
) (
    input  logic        wb_exc_i,
    input  logic        wb_eret_i,
    input  logic        ex_redirect_i,
    input  logic [31:0] wb_epc_i,
    input  logic [31:0] ex_redirect_pc_i,
    input  logic [31:0] seq_pc_i,
    output logic        flush_o,
    output logic [31:0] next_pc_o
);

    assign flush_o = wb_exc_i | wb_eret_i | ex_redirect_i;

    always_comb begin
        next_pc_o = seq_pc_i;
        if (wb_exc_i) begin
            next_pc_o = EXC_ENTRY;
        end else if (wb_eret_i) begin
            next_pc_o = wb_epc_i;
        end else if (ex_redirect_i) begin
            next_pc_o = ex_redirect_pc_i;
        end
    end

endmodule

// File: rtl/pf_next_pc.sv
// Pre-fetch stage: owns the fetch PC, sequences MIPS delay slots around taken
// predictions and applies flushes. Optional stat counters under PF_BP_STAT_EN.
module pf_next_pc
    import cpu_bp_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = CPU_RESET_PC,
    parameter logic [31:0] EXC_ENTRY = CPU_EXC_ENTRY
) (
    input  logic                 clk,
    input  logic                 resetn,
    output logic [BHT_IDX_W-1:0] bht_index,
    output logic [BTB_IDX_W-1:0] btb_index,
    output logic [BTB_TAG_W-1:0] btb_tag,
    output logic [31:0]          btb_pc,
    input  logic                 bp_taken,
    input  logic [31:0]          bp_target,
    input  logic                 if_allowin,
    output logic                 pf_valid,
    output logic [31:0]          pf_pc,
    output logic                 pf_pred_taken,
    output logic [31:0]          pf_pred_target,
    input  logic                 ex_redirect,
    input  logic [31:0]          ex_redirect_pc,
    input  logic                 wb_exc,
    input  logic                 wb_eret,
    input  logic [31:0]          wb_epc
`ifdef PF_BP_STAT_EN
    ,
    output logic [31:0]          stat_pred_taken,
    output logic [31:0]          stat_redirect
`endif
);

    logic [31:0] pc_q, pc_d;
    logic [0:0]  state_q, state_d;
    logic        valid_q, valid_d;
    logic [31:0] held_target_q, held_target_d;
    logic        hold_q, hold_d;
    pf_pred_t    hold_pred_q, hold_pred_d;

    logic [31:0] pc_plus4, pc_plus8, seq_next;
    logic        live_taken, accept, flush;
    pf_pred_t    live_pred, cur_pred;

    assign pc_plus4  = seq_pc(pc_q);
    assign pc_plus8  = pc_q + 32'd8;
    assign bht_index = pc_q[9:2];
    assign btb_index = pc_q[8:2];
    assign btb_tag   = pc_q[31:9];
    assign btb_pc    = pc_q;

    // A "taken" answer pointing at pc+4 is a BTB miss in disguise, not a branch.
    assign live_taken = (state_q == PF_RUN) && bp_taken && (bp_target != pc_plus4);

    always_comb begin
        live_pred.taken  = live_taken;
        live_pred.target = live_taken ? bp_target : pc_plus8;
    end

    // Once a PC stalls, the prediction shown with it is frozen until accepted.
    assign cur_pred = hold_q ? hold_pred_q : live_pred;
    assign accept   = valid_q && if_allowin;

    assign pf_valid       = valid_q;
    assign pf_pc          = pc_q;
    assign pf_pred_taken  = valid_q && cur_pred.taken;
    assign pf_pred_target = valid_q ? cur_pred.target : 32'd0;

    always_comb begin
        seq_next = pc_q;
        if (accept) begin
            seq_next = (state_q == PF_SLOT) ? held_target_q : pc_plus4;
        end
    end

    pf_redirect_mux #(
        .EXC_ENTRY(EXC_ENTRY)
    ) u_redirect_mux (
        .wb_exc_i        (wb_exc),
        .wb_eret_i       (wb_eret),
        .ex_redirect_i   (ex_redirect),
        .wb_epc_i        (wb_epc),
        .ex_redirect_pc_i(ex_redirect_pc),
        .seq_pc_i        (seq_next),
        .flush_o         (flush),
        .next_pc_o       (pc_d)
    );

    always_comb begin
        state_d       = state_q;
        held_target_d = held_target_q;
        hold_d        = hold_q;
        hold_pred_d   = hold_q ? hold_pred_q : live_pred;
        valid_d       = !flush;
        if (flush) begin
            state_d       = PF_RUN;
            held_target_d = 32'd0;
            hold_d        = 1'b0;
        end else if (accept) begin
            hold_d = 1'b0;
            if (state_q == PF_SLOT) begin
                state_d = PF_RUN;
            end else if (cur_pred.taken) begin
                state_d       = PF_SLOT;
                held_target_d = cur_pred.target;
            end
        end else if (valid_q) begin
            hold_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q          <= RESET_PC;
            state_q       <= PF_RUN;
            valid_q       <= 1'b0;
            held_target_q <= 32'd0;
            hold_q        <= 1'b0;
            hold_pred_q   <= '0;
        end else begin
            pc_q          <= pc_d;
            state_q       <= state_d;
            valid_q       <= valid_d;
            held_target_q <= held_target_d;
            hold_q        <= hold_d;
            hold_pred_q   <= hold_pred_d;
        end
    end

`ifdef PF_BP_STAT_EN
    logic [31:0] pred_taken_cnt_q, redirect_cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pred_taken_cnt_q <= 32'd0;
            redirect_cnt_q   <= 32'd0;
        end else begin
            if (accept && cur_pred.taken && !flush && (pred_taken_cnt_q != 32'hFFFF_FFFF)) begin
                pred_taken_cnt_q <= pred_taken_cnt_q + 32'd1;
            end
            if (ex_redirect && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign stat_pred_taken = pred_taken_cnt_q;
    assign stat_redirect   = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pf_next_pc.sv
// Bench for pf_next_pc: scenario tasks plus an expected-fetch queue drained on
// every accepted PC. Build with +define+PF_BP_STAT_EN to also cover the counters.
module tb_pf_next_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
        logic        chk_tgt;
    } exp_t;

    logic        clk, resetn;
    logic [7:0]  bht_index;
    logic [6:0]  btb_index;
    logic [22:0] btb_tag;
    logic [31:0] btb_pc;
    logic        bp_taken;
    logic [31:0] bp_target;
    logic        if_allowin;
    logic        pf_valid;
    logic [31:0] pf_pc;
    logic        pf_pred_taken;
    logic [31:0] pf_pred_target;
    logic        ex_redirect;
    logic [31:0] ex_redirect_pc;
    logic        wb_exc, wb_eret;
    logic [31:0] wb_epc;
`ifdef PF_BP_STAT_EN
    logic [31:0] stat_pred_taken, stat_redirect;
`endif

    logic [31:0] br_pc, br_tgt;
    exp_t        exp_q[$];
    int          checks, failures;
    int          exp_pred_cnt, exp_redir_cnt;

    pf_next_pc dut (
        .clk           (clk),
        .resetn        (resetn),
        .bht_index     (bht_index),
        .btb_index     (btb_index),
        .btb_tag       (btb_tag),
        .btb_pc        (btb_pc),
        .bp_taken      (bp_taken),
        .bp_target     (bp_target),
        .if_allowin    (if_allowin),
        .pf_valid      (pf_valid),
        .pf_pc         (pf_pc),
        .pf_pred_taken (pf_pred_taken),
        .pf_pred_target(pf_pred_target),
        .ex_redirect   (ex_redirect),
        .ex_redirect_pc(ex_redirect_pc),
        .wb_exc        (wb_exc),
        .wb_eret       (wb_eret),
        .wb_epc        (wb_epc)
`ifdef PF_BP_STAT_EN
        ,
        .stat_pred_taken(stat_pred_taken),
        .stat_redirect  (stat_redirect)
`endif
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Predictor stub: one branch at br_pc, everything else falls through.
    always_comb begin
        bp_taken  = (btb_pc == br_pc);
        bp_target = bp_taken ? br_tgt : btb_pc + 32'd4;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic flush_cycle(input logic exc, input logic eret, input logic redir,
                               input logic [31:0] epc, input logic [31:0] rpc);
        wb_exc         = exc;
        wb_eret        = eret;
        ex_redirect    = redir;
        wb_epc         = epc;
        ex_redirect_pc = rpc;
        if (redir) exp_redir_cnt++;
        tick();
        wb_exc      = 1'b0;
        wb_eret     = 1'b0;
        ex_redirect = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic taken,
                            input logic [31:0] tgt, input logic chk_tgt);
        exp_t e;
        e.pc      = pc;
        e.taken   = taken;
        e.tgt     = tgt;
        e.chk_tgt = chk_tgt;
        exp_q.push_back(e);
    endtask

    // Scoreboard drain: pops one expectation per accepted PC, sampled on negedge.
    task automatic drain(input bit rnd);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 400) begin
            if_allowin = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (pf_valid && if_allowin) begin
                e = exp_q.pop_front();
                checks++;
                if (pf_pc !== e.pc) begin
                    $display("FAIL sb_pc got=%h exp=%h", pf_pc, e.pc);
                    failures++;
                end
                checks++;
                if (pf_pred_taken !== e.taken) begin
                    $display("FAIL sb_taken pc=%h got=%b exp=%b", e.pc, pf_pred_taken, e.taken);
                    failures++;
                end
                if (e.chk_tgt) begin
                    checks++;
                    if (pf_pred_target !== e.tgt) begin
                        $display("FAIL sb_target pc=%h got=%h exp=%h", e.pc, pf_pred_target, e.tgt);
                        failures++;
                    end
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if_allowin = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL sb_timeout left=%0d exp=0", exp_q.size());
            failures++;
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        tick();
        tick();
        checks++; if (pf_pc !== 32'hBFC0_0000) begin $display("FAIL rst_pc got=%h exp=bfc00000", pf_pc); failures++; end
        checks++; if (pf_valid !== 1'b0) begin $display("FAIL rst_valid got=%b exp=0", pf_valid); failures++; end
        checks++; if (pf_pred_taken !== 1'b0) begin $display("FAIL rst_taken got=%b exp=0", pf_pred_taken); failures++; end
        checks++; if (pf_pred_target !== 32'd0) begin $display("FAIL rst_target got=%h exp=0", pf_pred_target); failures++; end
        checks++; if (bht_index !== 8'h00 || btb_tag !== 23'h5FE000) begin
            $display("FAIL rst_index got=%h/%h exp=00/5fe000", bht_index, btb_tag); failures++;
        end
`ifdef PF_BP_STAT_EN
        checks++; if (stat_pred_taken !== 32'd0 || stat_redirect !== 32'd0) begin
            $display("FAIL rst_stats got=%0d/%0d exp=0/0", stat_pred_taken, stat_redirect); failures++;
        end
`endif
        resetn = 1'b1;
        tick();
        checks++; if (pf_valid !== 1'b1) begin $display("FAIL rst_release_valid got=%b exp=1", pf_valid); failures++; end
        checks++; if (pf_pc !== 32'hBFC0_0000) begin $display("FAIL rst_release_pc got=%h exp=bfc00000", pf_pc); failures++; end
    endtask

    task automatic test_sequential;
        for (int i = 0; i < 4; i++) begin
            push_exp(32'hBFC0_0000 + 32'(4 * i), 1'b0, 32'hBFC0_0008 + 32'(4 * i), 1'b1);
        end
        drain(1'b0);
    endtask

    task automatic test_branch;
        br_pc  = 32'hBFC0_0010;
        br_tgt = 32'hBFC0_0100;
        push_exp(32'hBFC0_0010, 1'b1, 32'hBFC0_0100, 1'b1);
        push_exp(32'hBFC0_0014, 1'b0, 32'd0, 1'b0);
        push_exp(32'hBFC0_0100, 1'b0, 32'hBFC0_0108, 1'b1);
        exp_pred_cnt++;
        drain(1'b0);
    endtask

    task automatic test_stall_in_slot;
        flush_cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'hBFC0_0010);
        checks++; if (pf_valid !== 1'b0) begin $display("FAIL stall_flush_valid got=%b exp=0", pf_valid); failures++; end
        tick();
        if_allowin = 1'b0;
        checks++; if (pf_pred_taken !== 1'b1 || pf_pred_target !== 32'hBFC0_0100) begin
            $display("FAIL stall_pred got=%b/%h exp=1/bfc00100", pf_pred_taken, pf_pred_target); failures++;
        end
        tick();
        br_tgt = 32'hBFC0_0300;
        checks++; if (pf_pc !== 32'hBFC0_0010 || pf_pred_target !== 32'hBFC0_0100) begin
            $display("FAIL stall_pred_hold got=%h/%h exp=bfc00010/bfc00100", pf_pc, pf_pred_target); failures++;
        end
        if_allowin = 1'b1;
        tick();
        exp_pred_cnt++;
        br_pc      = 32'hBFC0_0014;
        br_tgt     = 32'hBFC0_0500;
        if_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (pf_pc !== 32'hBFC0_0014 || pf_valid !== 1'b1 || pf_pred_taken !== 1'b0) begin
                $display("FAIL stall_slot_hold cyc=%0d got=%h/%b/%b exp=bfc00014/1/0", i, pf_pc, pf_valid, pf_pred_taken);
                failures++;
            end
            tick();
        end
        if_allowin = 1'b1;
        tick();
        checks++; if (pf_pc !== 32'hBFC0_0100) begin $display("FAIL stall_slot_release got=%h exp=bfc00100", pf_pc); failures++; end
        br_pc  = 32'hBFC0_0010;
        br_tgt = 32'hBFC0_0100;
    endtask

    task automatic test_redirect_in_slot;
        flush_cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'hBFC0_0010);
        tick();
        tick();
        exp_pred_cnt++;
        checks++; if (pf_pc !== 32'hBFC0_0014) begin $display("FAIL rslot_enter got=%h exp=bfc00014", pf_pc); failures++; end
        flush_cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'hBFC0_0200);
        checks++; if (pf_valid !== 1'b0 || pf_pc !== 32'hBFC0_0200) begin
            $display("FAIL rslot_flush got=%b/%h exp=0/bfc00200", pf_valid, pf_pc); failures++;
        end
        push_exp(32'hBFC0_0200, 1'b0, 32'hBFC0_0208, 1'b1);
        push_exp(32'hBFC0_0204, 1'b0, 32'hBFC0_020C, 1'b1);
        drain(1'b0);
        br_pc = 32'h0000_0001;
    endtask

    task automatic test_flush_priority;
        flush_cycle(1'b1, 1'b1, 1'b1, 32'h8000_1234, 32'hBFC0_0200);
        checks++; if (pf_valid !== 1'b0 || pf_pc !== 32'hBFC0_0380) begin
            $display("FAIL prio_all got=%b/%h exp=0/bfc00380", pf_valid, pf_pc); failures++;
        end
        tick();
        checks++; if (pf_valid !== 1'b1) begin $display("FAIL prio_revalid got=%b exp=1", pf_valid); failures++; end
        flush_cycle(1'b0, 1'b1, 1'b0, 32'h8000_1234, 32'd0);
        checks++; if (pf_pc !== 32'h8000_1234) begin $display("FAIL prio_eret got=%h exp=80001234", pf_pc); failures++; end
        tick();
        flush_cycle(1'b0, 1'b1, 1'b1, 32'h8000_2000, 32'hBFC0_0600);
        checks++; if (pf_pc !== 32'h8000_2000) begin $display("FAIL prio_eret_redir got=%h exp=80002000", pf_pc); failures++; end
        br_pc  = 32'h8000_2000;
        br_tgt = 32'h8000_3000;
        tick();
        checks++; if (pf_pred_taken !== 1'b1) begin $display("FAIL prio_pred got=%b exp=1", pf_pred_taken); failures++; end
        flush_cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'hBFC0_0400);
        checks++; if (pf_valid !== 1'b0 || pf_pc !== 32'hBFC0_0400) begin
            $display("FAIL prio_redir_vs_taken got=%b/%h exp=0/bfc00400", pf_valid, pf_pc); failures++;
        end
        br_pc = 32'h0000_0001;
        push_exp(32'hBFC0_0400, 1'b0, 32'hBFC0_0408, 1'b1);
        push_exp(32'hBFC0_0404, 1'b0, 32'hBFC0_040C, 1'b1);
        drain(1'b0);
    endtask

    task automatic test_btb_miss;
        flush_cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'hBFC0_0800);
        br_pc  = 32'hBFC0_0804;
        br_tgt = 32'hBFC0_0808;
        push_exp(32'hBFC0_0800, 1'b0, 32'hBFC0_0808, 1'b1);
        push_exp(32'hBFC0_0804, 1'b0, 32'hBFC0_080C, 1'b1);
        push_exp(32'hBFC0_0808, 1'b0, 32'hBFC0_0810, 1'b1);
        push_exp(32'hBFC0_080C, 1'b0, 32'hBFC0_0814, 1'b1);
        drain(1'b0);
        br_pc = 32'h0000_0001;
`ifdef PF_BP_STAT_EN
        checks++; if (stat_pred_taken !== 32'(exp_pred_cnt)) begin
            $display("FAIL stat_pred got=%0d exp=%0d", stat_pred_taken, exp_pred_cnt); failures++;
        end
        checks++; if (stat_redirect !== 32'(exp_redir_cnt)) begin
            $display("FAIL stat_redirect got=%0d exp=%0d", stat_redirect, exp_redir_cnt); failures++;
        end
`endif
    endtask

    task automatic test_back_to_back;
        flush_cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'hBFC0_1000);
        for (int i = 0; i < 16; i++) begin
            push_exp(32'hBFC0_1000 + 32'(4 * i), 1'b0, 32'hBFC0_1008 + 32'(4 * i), 1'b1);
        end
        drain(1'b1);
    endtask

    task automatic test_wrap;
        flush_cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFF8);
        push_exp(32'hFFFF_FFF8, 1'b0, 32'h0000_0000, 1'b1);
        push_exp(32'hFFFF_FFFC, 1'b0, 32'h0000_0004, 1'b1);
        push_exp(32'h0000_0000, 1'b0, 32'h0000_0008, 1'b1);
        drain(1'b0);
        flush_cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'hBFC0_0A02);
        push_exp(32'hBFC0_0A02, 1'b0, 32'hBFC0_0A0A, 1'b1);
        push_exp(32'hBFC0_0A06, 1'b0, 32'hBFC0_0A0E, 1'b1);
        drain(1'b0);
    endtask

    task automatic test_reset_mid_slot;
        br_pc  = 32'hBFC0_0010;
        br_tgt = 32'hBFC0_0100;
        flush_cycle(1'b0, 1'b0, 1'b1, 32'd0, 32'hBFC0_0010);
        tick();
        tick();
        checks++; if (pf_pc !== 32'hBFC0_0014) begin $display("FAIL rslot_mid_enter got=%h exp=bfc00014", pf_pc); failures++; end
        resetn = 1'b0;
        tick();
        checks++; if (pf_pc !== 32'hBFC0_0000 || pf_valid !== 1'b0 || pf_pred_target !== 32'd0) begin
            $display("FAIL rst_mid got=%h/%b/%h exp=bfc00000/0/0", pf_pc, pf_valid, pf_pred_target); failures++;
        end
`ifdef PF_BP_STAT_EN
        checks++; if (stat_pred_taken !== 32'd0 || stat_redirect !== 32'd0) begin
            $display("FAIL rst_mid_stats got=%0d/%0d exp=0/0", stat_pred_taken, stat_redirect); failures++;
        end
`endif
        exp_pred_cnt  = 0;
        exp_redir_cnt = 0;
        resetn = 1'b1;
        br_pc  = 32'h0000_0001;
        tick();
        push_exp(32'hBFC0_0000, 1'b0, 32'hBFC0_0008, 1'b1);
        push_exp(32'hBFC0_0004, 1'b0, 32'hBFC0_000C, 1'b1);
        drain(1'b0);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        exp_pred_cnt   = 0;
        exp_redir_cnt  = 0;
        resetn         = 1'b0;
        if_allowin     = 1'b1;
        ex_redirect    = 1'b0;
        ex_redirect_pc = 32'd0;
        wb_exc         = 1'b0;
        wb_eret        = 1'b0;
        wb_epc         = 32'd0;
        br_pc          = 32'h0000_0001;
        br_tgt         = 32'd0;

        test_reset();
        test_sequential();
        test_branch();
        test_stall_in_slot();
        test_redirect_in_slot();
        test_flush_priority();
        test_btb_miss();
        test_back_to_back();
        test_wrap();
        test_reset_mid_slot();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
